ddp_merge_arbiter: RTL and testbench



---
 rtl/ddp_merge_arbiter.sv | 156 +++++++++++++++
 tb/tb_ddp_merge_arbiter.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddp_merge_arbiter.sv
// Round-robin merge controller: N 4-phase Send/Ack requesters share one downstream stage.
// Inputs are synchronised, the granted payload is latched and stuck handshakes are flagged.
module ddp_merge_arbiter #(
    parameter int N           = 4,
    parameter int DATA_W      = 16,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 255,
    parameter int CNT_W       = 8
) (
    input  logic                CLK,
    input  logic                MR_n,
    input  logic [N-1:0]        Send_in,
    input  logic [N*DATA_W-1:0] Data_in,
    output logic [N-1:0]        Ack_out,
    output logic                Send_out,
    output logic [DATA_W-1:0]   Data_out,
    input  logic                Ack_in,
    output logic [N-1:0]        Grant,
    output logic                Busy,
    output logic                Err_timeout,
    input  logic                Err_clr
);
    localparam int                PTR_W   = $clog2(N);
    localparam int unsigned       NU      = N;
    localparam logic [CNT_W-1:0]  TO_VAL  = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0]  CNT_MAX = '1;
    localparam logic [PTR_W-1:0]  LAST    = PTR_W'(N - 1);

    typedef enum logic [1:0] {IDLE, SEND, ACK_UP, RELEASE} state_t;

    state_t               state_q, state_d;
    logic [N-1:0]         send_sync_q [SYNC_STAGES];
    logic [SYNC_STAGES-1:0] ack_sync_q;
    logic [N-1:0]         send_s;
    logic                 ack_s;
    logic [PTR_W-1:0]     ptr_q, ptr_d, gidx_q, gidx_d, pick, idx;
    logic                 found;
    logic [N-1:0]         grant_q, grant_d, ack_q, ack_d;
    logic                 send_q, send_d;
    logic [DATA_W-1:0]    data_q, data_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 hit;
    logic                 err_q, err_d;

    always_ff @(posedge CLK or negedge MR_n) begin
        if (!MR_n) begin
            for (int unsigned s = 0; s < SYNC_STAGES; s++) send_sync_q[s] <= '0;
            ack_sync_q <= '0;
        end else begin
            send_sync_q[0] <= Send_in;
            for (int unsigned s = 1; s < SYNC_STAGES; s++) send_sync_q[s] <= send_sync_q[s-1];
            ack_sync_q <= {ack_sync_q[SYNC_STAGES-2:0], Ack_in};
        end
    end

    assign send_s = send_sync_q[SYNC_STAGES-1];
    assign ack_s  = ack_sync_q[SYNC_STAGES-1];

    // First requesting index at or after ptr, wrapping modulo N.
    always_comb begin
        pick  = '0;
        found = 1'b0;
        idx   = '0;
        for (int unsigned k = 0; k < NU; k++) begin
            idx = PTR_W'((32'(ptr_q) + k) % NU);
            if (!found && send_s[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gidx_d  = gidx_q;
        grant_d = grant_q;
        ack_d   = ack_q;
        send_d  = send_q;
        data_d  = data_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    gidx_d  = pick;
                    grant_d = N'(1) << pick;
                    send_d  = 1'b1;
                    data_d  = Data_in[pick*DATA_W +: DATA_W];
                    state_d = SEND;
                end
            end
            SEND: begin
                if (ack_s) begin
                    send_d  = 1'b0;
                    ack_d   = grant_q;
                    state_d = ACK_UP;
                end
            end
            ACK_UP: begin
                if (!ack_s && !send_s[gidx_q]) begin
                    ack_d   = '0;
                    state_d = RELEASE;
                end
            end
            RELEASE: begin
                ptr_d   = (gidx_q == LAST) ? '0 : gidx_q + 1'b1;
                grant_d = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Counter restarts on any state change; the flag is set when the next count reaches TIMEOUT.
    always_comb begin
        cnt_d = '0;
        hit   = 1'b0;
        if ((state_d == state_q) && ((state_q == SEND) || (state_q == ACK_UP))) begin
            cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
            hit   = (TIMEOUT != 0) && (cnt_d == TO_VAL);
        end
        err_d = Err_clr ? 1'b0 : err_q;
        if (hit) err_d = 1'b1;
    end

    always_ff @(posedge CLK or negedge MR_n) begin
        if (!MR_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            gidx_q  <= '0;
            grant_q <= '0;
            ack_q   <= '0;
            send_q  <= 1'b0;
            data_q  <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gidx_q  <= gidx_d;
            grant_q <= grant_d;
            ack_q   <= ack_d;
            send_q  <= send_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    assign Ack_out     = ack_q;
    assign Send_out    = send_q;
    assign Data_out    = data_q;
    assign Grant       = grant_q;
    assign Busy        = (state_q != IDLE);
    assign Err_timeout = err_q;

endmodule

// File: tb/tb_ddp_merge_arbiter.sv
// Bench for ddp_merge_arbiter: acts as the requesters and the downstream stage,
// predicting grant order from a round-robin pointer model.
module tb_ddp_merge_arbiter;
    localparam int N  = 4;
    localparam int DW = 16;

    logic            CLK = 1'b0;
    logic            MR_n;
    logic [N-1:0]    Send_in;
    logic [N*DW-1:0] Data_in;
    logic [N-1:0]    Ack_out;
    logic            Send_out;
    logic [DW-1:0]   Data_out;
    logic            Ack_in;
    logic [N-1:0]    Grant;
    logic            Busy;
    logic            Err_timeout;
    logic            Err_clr;

    int checks   = 0;
    int failures = 0;
    int mptr     = 0;

    ddp_merge_arbiter #(
        .N(N), .DATA_W(DW), .SYNC_STAGES(2), .TIMEOUT(10), .CNT_W(8)
    ) dut (
        .CLK(CLK), .MR_n(MR_n), .Send_in(Send_in), .Data_in(Data_in),
        .Ack_out(Ack_out), .Send_out(Send_out), .Data_out(Data_out),
        .Ack_in(Ack_in), .Grant(Grant), .Busy(Busy),
        .Err_timeout(Err_timeout), .Err_clr(Err_clr)
    );

    always #5 CLK = ~CLK;

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic wait_send_out(input logic v, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (Send_out === v) begin ok = 1'b1; return; end
            tick();
        end
    endtask

    task automatic wait_ack(input logic nonzero, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if ((|Ack_out) === nonzero) begin ok = 1'b1; return; end
            tick();
        end
    endtask

    function automatic int rr_pick(input logic [N-1:0] m, input int p);
        int id;
        for (int k = 0; k < N; k++) begin
            id = (p + k) % N;
            if (m[id]) return id;
        end
        return -1;
    endfunction

    task automatic run_round(input logic [N-1:0] m, input string tag);
        logic [DW-1:0] pay [N];
        logic [N-1:0]  rem, exp_oh, ga;
        int            eg;
        bit            ok;
        rem = m;
        for (int i = 0; i < N; i++) begin
            pay[i] = DW'($urandom);
            Data_in[i*DW +: DW] = pay[i];
        end
        Send_in = m;
        while (rem != '0) begin
            eg = rr_pick(rem, mptr);
            exp_oh = '0;
            exp_oh[eg] = 1'b1;
            wait_send_out(1'b1, ok);
            checks++;
            if (!ok) begin
                failures++;
                $display("FAIL %s grant_wait: Send_out=%b required 1", tag, Send_out);
                Send_in = '0;
                return;
            end
            checks++;
            if (Grant !== exp_oh) begin
                failures++;
                $display("FAIL %s grant: got %b required %b", tag, Grant, exp_oh);
            end
            checks++;
            if (Data_out !== pay[eg]) begin
                failures++;
                $display("FAIL %s data: got %h required %h", tag, Data_out, pay[eg]);
            end
            checks++;
            if (Busy !== 1'b1) begin
                failures++;
                $display("FAIL %s busy: got %b required 1", tag, Busy);
            end
            repeat ($urandom_range(0, 3)) tick();
            Ack_in = 1'b1;
            wait_ack(1'b1, ok);
            checks++;
            if (!ok || Ack_out !== exp_oh || Send_out !== 1'b0) begin
                failures++;
                $display("FAIL %s ack_up: Ack_out=%b Send_out=%b required %b 0", tag, Ack_out, Send_out, exp_oh);
            end
            checks++;
            if (!$onehot0(Ack_out)) begin
                failures++;
                $display("FAIL %s ack_onehot: got %b required at most one bit", tag, Ack_out);
            end
            ga = Ack_out;
            Send_in = Send_in & ~ga;
            rem = rem & ~ga;
            mptr = (eg + 1) % N;
            if (!ok || ga == '0) begin
                Send_in = '0;
                Ack_in = 1'b0;
                return;
            end
            repeat ($urandom_range(0, 3)) tick();
            Ack_in = 1'b0;
            wait_ack(1'b0, ok);
            checks++;
            if (!ok) begin
                failures++;
                $display("FAIL %s ack_release: Ack_out=%b required 0", tag, Ack_out);
                return;
            end
            tick();
            checks++;
            if (Grant !== '0 || Send_out !== 1'b0) begin
                failures++;
                $display("FAIL %s gap: Grant=%b Send_out=%b required 0 0", tag, Grant, Send_out);
            end
        end
    endtask

    task automatic do_reset;
        MR_n = 1'b0;
        tick();
        tick();
        MR_n = 1'b1;
        tick();
        mptr = 0;
    endtask

    task automatic test_reset;
        MR_n = 1'b0;
        repeat (2) tick();
        checks++;
        if (Send_out !== 1'b0 || Ack_out !== '0 || Grant !== '0 || Busy !== 1'b0 ||
            Data_out !== '0 || Err_timeout !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: Send_out=%b Ack_out=%b Grant=%b Busy=%b Data_out=%h Err=%b required all 0",
                     Send_out, Ack_out, Grant, Busy, Data_out, Err_timeout);
        end
        MR_n = 1'b1;
        tick();
        mptr = 0;
    endtask

    task automatic test_single;
        bit ok;
        Data_in[0 +: DW] = 16'hA5A5;
        Send_in = 4'b0001;
        tick();
        tick();
        checks++;
        if (Send_out !== 1'b0) begin
            failures++;
            $display("FAIL single_latency_early: Send_out=%b required 0", Send_out);
        end
        tick();
        checks++;
        if (Send_out !== 1'b1 || Grant !== 4'b0001 || Data_out !== 16'hA5A5) begin
            failures++;
            $display("FAIL single_grant: Send_out=%b Grant=%b Data_out=%h required 1 0001 a5a5",
                     Send_out, Grant, Data_out);
        end
        repeat (2) tick();
        Ack_in = 1'b1;
        wait_ack(1'b1, ok);
        checks++;
        if (!ok || Ack_out !== 4'b0001) begin
            failures++;
            $display("FAIL single_ack: Ack_out=%b required 0001", Ack_out);
        end
        Send_in = '0;
        Ack_in = 1'b0;
        wait_ack(1'b0, ok);
        tick();
        checks++;
        if (!ok || Grant !== '0 || Busy !== 1'b0 || Data_out !== 16'hA5A5) begin
            failures++;
            $display("FAIL single_done: Grant=%b Busy=%b Data_out=%h required 0000 0 a5a5", Grant, Busy, Data_out);
        end
        mptr = 1;
    endtask

    task automatic test_fairness;
        run_round(4'b1001, "fair_skip");
        run_round(4'b1111, "fair_ptr1");
    endtask

    task automatic test_contention;
        do_reset();
        run_round(4'b1111, "contention");
        run_round(4'b0001, "contention_wrap");
    endtask

    task automatic test_timeout;
        bit ok;
        Data_in[2*DW +: DW] = DW'($urandom);
        Send_in = 4'b0100;
        wait_send_out(1'b1, ok);
        repeat (9) tick();
        checks++;
        if (!ok || Err_timeout !== 1'b0) begin
            failures++;
            $display("FAIL timeout_early: Err=%b required 0", Err_timeout);
        end
        tick();
        checks++;
        if (Err_timeout !== 1'b1 || Send_out !== 1'b1) begin
            failures++;
            $display("FAIL timeout_set: Err=%b Send_out=%b required 1 1", Err_timeout, Send_out);
        end
        Ack_in = 1'b1;
        wait_ack(1'b1, ok);
        Send_in = '0;
        Ack_in = 1'b0;
        wait_ack(1'b0, ok);
        checks++;
        if (!ok || Err_timeout !== 1'b1) begin
            failures++;
            $display("FAIL timeout_sticky: Err=%b required 1", Err_timeout);
        end
        Err_clr = 1'b1;
        tick();
        Err_clr = 1'b0;
        checks++;
        if (Err_timeout !== 1'b0) begin
            failures++;
            $display("FAIL timeout_clear: Err=%b required 0", Err_timeout);
        end
        mptr = 3;
        Send_in = 4'b0100;
        wait_send_out(1'b1, ok);
        repeat (9) tick();
        Err_clr = 1'b1;
        tick();
        Err_clr = 1'b0;
        checks++;
        if (!ok || Err_timeout !== 1'b1) begin
            failures++;
            $display("FAIL timeout_set_wins: Err=%b required 1", Err_timeout);
        end
        Ack_in = 1'b1;
        wait_ack(1'b1, ok);
        Send_in = '0;
        Ack_in = 1'b0;
        wait_ack(1'b0, ok);
        tick();
        mptr = 3;
    endtask

    task automatic test_reset_midop;
        bit ok;
        Send_in = 4'b0100;
        wait_send_out(1'b1, ok);
        Ack_in = 1'b1;
        wait_ack(1'b1, ok);
        #2;
        MR_n = 1'b0;
        #1;
        checks++;
        if (!ok || Ack_out !== '0 || Send_out !== 1'b0 || Grant !== '0 || Busy !== 1'b0 ||
            Data_out !== '0 || Err_timeout !== 1'b0) begin
            failures++;
            $display("FAIL midop_reset: Ack_out=%b Send_out=%b Grant=%b Busy=%b Data_out=%h Err=%b required all 0",
                     Ack_out, Send_out, Grant, Busy, Data_out, Err_timeout);
        end
        Send_in = '0;
        Ack_in = 1'b0;
        tick();
        MR_n = 1'b1;
        mptr = 0;
        tick();
        run_round(4'b1010, "after_reset");
    endtask

    task automatic test_early_withdraw;
        Send_in = 4'b0100;
        #3;
        Send_in = '0;
        for (int c = 0; c < 8; c++) begin
            tick();
            checks++;
            if (Busy !== 1'b0 || Grant !== '0) begin
                failures++;
                $display("FAIL withdraw cycle %0d: Busy=%b Grant=%b required 0 0000", c, Busy, Grant);
            end
        end
    endtask

    task automatic test_random;
        logic [N-1:0] m;
        for (int r = 0; r < 8; r++) begin
            m = N'($urandom_range(1, 15));
            run_round(m, "random");
        end
        checks++;
        if (Err_timeout !== 1'b0) begin
            failures++;
            $display("FAIL random_no_timeout: Err=%b required 0", Err_timeout);
        end
    endtask

    initial begin
        MR_n    = 1'b0;
        Send_in = '0;
        Data_in = '0;
        Ack_in  = 1'b0;
        Err_clr = 1'b0;
        test_reset();
        test_single();
        test_fairness();
        test_contention();
        test_timeout();
        test_reset_midop();
        test_early_withdraw();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

endmodule
